// File: rtl/spart_io_pkg.sv
// spart_io_pkg: shared state encoding and byte-select constants for the SPART I/O sequencer
package spart_io_pkg;
  typedef enum logic [2:0] {IDLE, TX_B0, TX_B1, RX_B0, RX_B1, RX_DONE} state_e;
  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;
endpackage

// File: rtl/spart_io_ctrl.sv
// spart_io_ctrl: sequences 8/16-bit SPART transmit/receive and stalls the pipeline (ports: clk, rst, tx_req, rx_req, wide, spart_tbr/rda/rx in; byte_sel, spart_wr/rd, rx_data, stall out)
module spart_io_ctrl
  import spart_io_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic        rx_req,
  input  logic        wide,
  input  logic        spart_tbr,
  input  logic        spart_rda,
  input  logic [7:0]  spart_rx,
  output logic        byte_sel,
  output logic        spart_wr,
  output logic        spart_rd,
  output logic [15:0] rx_data,
  output logic        stall
);
  localparam logic FIRST = HI_FIRST ? BYTE_HI : BYTE_LO;
  localparam logic SECOND = HI_FIRST ? BYTE_LO : BYTE_HI;
  state_e state_q, state_d;
  logic wide_q, wide_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic in_tx, in_rx, last_wr;
  always_comb begin
    state_d = state_q;
    wide_d = wide_q;
    rx_data_d = rx_data_q;
    case (state_q)
      IDLE: begin
        if (tx_req) begin
          state_d = TX_B0;
          wide_d = wide;
        end else if (rx_req) begin
          state_d = RX_B0;
          wide_d = wide;
          rx_data_d = '0;
        end
      end
      TX_B0: if (spart_tbr) state_d = wide_q ? TX_B1 : IDLE;
      TX_B1: if (spart_tbr) state_d = IDLE;
      RX_B0: begin
        if (spart_rda) begin
          state_d = wide_q ? RX_B1 : RX_DONE;
          // narrow receives always land in the low byte regardless of order
          if (wide_q && HI_FIRST) rx_data_d[15:8] = spart_rx;
          else rx_data_d[7:0] = spart_rx;
        end
      end
      RX_B1: begin
        if (spart_rda) begin
          state_d = RX_DONE;
          if (HI_FIRST) rx_data_d[7:0] = spart_rx;
          else rx_data_d[15:8] = spart_rx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wide_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q <= state_d;
      wide_q <= wide_d;
      rx_data_q <= rx_data_d;
    end
  end
  assign in_tx = (state_q == TX_B0) || (state_q == TX_B1);
  assign in_rx = (state_q == RX_B0) || (state_q == RX_B1);
  // the final write retires the instruction, so stall drops in that same cycle
  assign last_wr = spart_tbr && ((state_q == TX_B1) || (state_q == TX_B0 && !wide_q));
  assign byte_sel = (state_q == TX_B0) ? FIRST : (state_q == TX_B1) ? SECOND : BYTE_LO;
  assign spart_wr = in_tx && spart_tbr;
  assign spart_rd = in_rx && spart_rda;
  assign stall = (state_q == IDLE) ? (tx_req | rx_req) : in_tx ? !last_wr : in_rx;
  assign rx_data = rx_data_q;
endmodule

// File: doc/spart_io_ctrl.md
# spart_io_ctrl

Sequencer between the pipeline and the SPART for 8- and 16-bit serial I/O instructions. On a transmit request it walks the SPART byte-select through one or two bytes, issuing a write strobe per byte when the transmit buffer is ready. On a receive request it pops one or two bytes from the SPART and assembles a 16-bit result for the writeback source selector. The pipeline is stalled until the transfer completes.

## Interface
Parameters:
- HI_FIRST, 0: byte order for wide transfers; 0 = low byte first, 1 = high byte first.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tx_req  in  1  transmit instruction in stage; held until stall drops
- rx_req  in  1  receive instruction in stage; held until stall drops
- wide  in  1  1 = 16-bit transfer, 0 = low byte only; sampled at acceptance
- spart_tbr  in  1  SPART transmit buffer ready
- spart_rda  in  1  SPART receive data available
- spart_rx  in  8  SPART received byte
- byte_sel  out  1  byte select to the SPART byte mux (0 = p1[7:0], 1 = p1[15:8])
- spart_wr  out  1  one-cycle write strobe to SPART
- spart_rd  out  1  one-cycle read/pop strobe to SPART
- rx_data  out  16  assembled receive word, to writeback source selector
- stall  out  1  freeze pipeline

## Operation
- States: IDLE, TX_B0, TX_B1, RX_B0, RX_B1, RX_DONE.
- IDLE: tx_req → TX_B0; else rx_req → RX_B0; `wide` latched. tx_req wins if both are high. Both high is illegal but deterministic.
- TX_B0: byte_sel = first byte (HI_FIRST ? 1 : 0). While spart_tbr=0, wait. When spart_tbr=1: spart_wr=1; wide → TX_B1, else → IDLE.
- TX_B1: byte_sel = second byte. When spart_tbr=1: spart_wr=1, → IDLE.
- RX_B0: when spart_rda=1: spart_rd=1; capture spart_rx into first-byte slot; wide → RX_B1, else → RX_DONE.
- RX_B1: when spart_rda=1: spart_rd=1; capture into second-byte slot; → RX_DONE.
- RX_DONE: → IDLE unconditionally.
- Narrow receive: rx_data = {8'h00, byte}. Wide receive: rx_data = {hi, lo}, placed per HI_FIRST.
- rx_data is registered. It is cleared to 0 at the start of each receive (IDLE→RX_B0) and holds its value between transfers.
- stall = 1 in IDLE when tx_req|rx_req is high, and in TX_B0/TX_B1/RX_B0/RX_B1. Exception: in TX_B0/TX_B1, stall = 0 in the cycle the final spart_wr fires.
- stall = 0 in RX_DONE and in IDLE when no request is pending.
- byte_sel = 0 in every non-TX state.

## Timing
- Reset values: state IDLE, byte_sel 0, spart_wr 0, spart_rd 0, rx_data 16'h0000, stall 0. Reset mid-transfer aborts it immediately. A byte already strobed is not retried.
- spart_wr, spart_rd, byte_sel and stall are combinational from state and inputs. rx_data is a register.
- Minimum latency with tbr/rda held high:
  - narrow TX: 2 cycles (accept, write)
  - wide TX: 3 cycles
  - narrow RX: 3 cycles (accept, read, done)
  - wide RX: 4 cycles
- The pipeline's p1 operand is stable for the whole TX because stall holds the stage.
- The instruction retires at the clock edge ending the cycle with stall=0. The FSM is in IDLE the following cycle, so back-to-back requests incur no extra bubble.
- At most one spart_wr or spart_rd per cycle. They are never both high.
- spart_tbr or spart_rda dropping mid-wide-transfer stalls in TX_B1 or RX_B1 indefinitely. There is no timeout.

## Structure
- Shared package spart_io_pkg holds:
  - state enum (3-bit encoding)
  - constants BYTE_LO=1'b0, BYTE_HI=1'b1
- Single module. No sub-module; the FSM and the 16-bit assembly register are small enough to stay together.

## Test plan
- Narrow TX, tbr=1, tx_req=1, wide=0 → spart_wr pulses once with byte_sel=0; stall high 1 cycle, low on the write cycle; FSM back to IDLE.
- Wide TX, HI_FIRST=0, tbr low for 3 cycles in TX_B1 → first write with byte_sel=0, 3 stall cycles, then second write with byte_sel=1; exactly 2 strobes.
- Wide RX, rda=1, spart_rx=8'h34 then 8'h12 → rx_data=16'h1234 in RX_DONE; stall=0 there; 2 spart_rd pulses.
- Narrow RX after wide RX, spart_rx=8'hAB → rx_data=16'h00AB (upper byte cleared).
- tx_req and rx_req both high → TX path taken, no spart_rd.
- rst asserted in TX_B1 → outputs 0 asynchronously, no further spart_wr; after release, a new narrow TX completes normally.
